// File: rtl/pilha_rpn_pkg.sv
// -----------------------------------------------------------------------------
// pilha_rpn_pkg
// Shared definitions for the RPN operand stack: command codes, control FSM
// state encoding and the per-entry next-value select used by pilha_rpn_reg.
// -----------------------------------------------------------------------------
package pilha_rpn_pkg;

    // Command codes presented on i_cmd
    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_PUSH  = 3'd1;
    localparam logic [2:0] CMD_POP   = 3'd2;
    localparam logic [2:0] CMD_DUP   = 3'd3;
    localparam logic [2:0] CMD_SWAP  = 3'd4;
    localparam logic [2:0] CMD_BINOP = 3'd5;
    localparam logic [2:0] CMD_CLEAR = 3'd6;
    localparam logic [2:0] CMD_UNOP  = 3'd7;

    // Control FSM: IDLE accepts commands, WAIT holds the stack for the ALU
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Next-value select of one stack entry
    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,   // keep current value
        SEL_LOAD  = 2'd1,   // take the entry above (or new data for entry 0)
        SEL_SHIFT = 2'd2    // take the entry below (stack moves toward TOS)
    } sel_t;

endpackage

// File: rtl/pilha_rpn_reg.sv
// -----------------------------------------------------------------------------
// pilha_rpn_reg
// One stack entry: a WIDTH-bit register with a hold / load / shift select.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_sel           next-value select (sel_t)
//   i_load          value taken on SEL_LOAD
//   i_shift         value taken on SEL_SHIFT
//   o_q             stored value
// -----------------------------------------------------------------------------
module pilha_rpn_reg
    import pilha_rpn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  sel_t             i_sel,
    input  logic [WIDTH-1:0] i_load,
    input  logic [WIDTH-1:0] i_shift,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // NOTE: storage is reset too, so the stack contents are deterministic
    // after reset even though entries above count are never observed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else begin
            // NOTE: non-blocking assignment for every sequential register.
            case (i_sel)
                SEL_LOAD:  r_q <= i_load;
                SEL_SHIFT: r_q <= i_shift;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pilha_rpn.sv
// -----------------------------------------------------------------------------
// pilha_rpn
// RPN operand stack of DEPTH words of WIDTH bits with an ALU start/done
// handshake. Entry 0 is TOS, entry 1 is NOS.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_cmd_valid/i_cmd  command request and code (pilha_rpn_pkg CMD_*)
//   o_cmd_ready        high in IDLE; command accepted on valid && ready
//   i_d                data for PUSH
//   o_alu_start        one-cycle ALU launch pulse
//   i_alu_done         ALU result valid (only sampled in WAIT)
//   i_alu_result       ALU result
//   o_tdp / o_pdp      TOS / NOS, forced to 0 when not present
//   o_count            number of valid entries
//   o_empty / o_full   occupancy flags
//   o_err / i_err_clr  sticky stack error and its synchronous clear
// -----------------------------------------------------------------------------
module pilha_rpn
    import pilha_rpn_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    input  logic [2:0]       i_cmd,
    output logic             o_cmd_ready,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_alu_start,
    input  logic             i_alu_done,
    input  logic [WIDTH-1:0] i_alu_result,
    output logic [WIDTH-1:0] o_tdp,
    output logic [WIDTH-1:0] o_pdp,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_err,
    input  logic             i_err_clr
);

    state_t           r_state;
    logic             r_pend_bin;   // operation in flight is a BINOP
    logic             r_alu_start;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic [WIDTH-1:0] w_q [DEPTH];
    sel_t             w_sel [DEPTH];
    logic [WIDTH-1:0] w_load0;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_accept, w_done, w_illegal, w_exec, w_is_alu;
    logic             w_is_empty, w_is_full, w_lt2;

    assign w_is_empty = (r_count == '0);
    assign w_is_full  = (r_count == CNT_W'(DEPTH));
    assign w_lt2      = (r_count <  CNT_W'(2));

    assign w_accept = i_cmd_valid && (r_state == ST_IDLE);
    assign w_done   = i_alu_done  && (r_state == ST_WAIT);
    assign w_is_alu = (i_cmd == CMD_BINOP) || (i_cmd == CMD_UNOP);
    assign w_exec   = w_accept && !w_illegal;

    // Entry 0 loads push data in IDLE and the ALU result in WAIT
    assign w_load0 = (r_state == ST_WAIT) ? i_alu_result : i_d;

    always_comb begin
        case (i_cmd)
            CMD_PUSH:  w_illegal = w_is_full;
            CMD_POP:   w_illegal = w_is_empty;
            CMD_DUP:   w_illegal = w_is_empty || w_is_full;
            CMD_SWAP:  w_illegal = w_lt2;
            CMD_BINOP: w_illegal = w_lt2;
            CMD_UNOP:  w_illegal = w_is_empty;
            default:   w_illegal = 1'b0;
        endcase
    end

    // Per-entry select and next occupancy
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        for (int i = 0; i < DEPTH; i++) w_sel[i] = SEL_HOLD;
        w_count_nxt = r_count;
        if (w_done) begin
            w_sel[0] = SEL_LOAD;
            if (r_pend_bin) begin
                // NOS is consumed: everything below moves up one slot
                for (int i = 1; i < DEPTH; i++) w_sel[i] = SEL_SHIFT;
                w_count_nxt = r_count - CNT_W'(1);
            end
        end else if (w_exec) begin
            case (i_cmd)
                CMD_PUSH: begin
                    for (int i = 0; i < DEPTH; i++) w_sel[i] = SEL_LOAD;
                    w_count_nxt = r_count + CNT_W'(1);
                end
                CMD_POP: begin
                    for (int i = 0; i < DEPTH; i++) w_sel[i] = SEL_SHIFT;
                    w_count_nxt = r_count - CNT_W'(1);
                end
                CMD_DUP: begin
                    // TOS stays, a copy of it is pushed below
                    for (int i = 1; i < DEPTH; i++) w_sel[i] = SEL_LOAD;
                    w_count_nxt = r_count + CNT_W'(1);
                end
                CMD_SWAP: begin
                    w_sel[0] = SEL_SHIFT;
                    w_sel[1] = SEL_LOAD;
                end
                CMD_CLEAR: w_count_nxt = '0;
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [WIDTH-1:0] w_ld;
        logic [WIDTH-1:0] w_sh;
        if (g == 0) begin : g_top
            assign w_ld = w_load0;
        end else begin : g_below
            assign w_ld = w_q[g-1];
        end
        if (g == DEPTH - 1) begin : g_bottom
            assign w_sh = '0;
        end else begin : g_above
            assign w_sh = w_q[g+1];
        end
        pilha_rpn_reg #(.WIDTH(WIDTH)) u_reg (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_sel   (w_sel[g]),
            .i_load  (w_ld),
            .i_shift (w_sh),
            .o_q     (w_q[g])
        );
    end

    // Control FSM, occupancy counter and sticky error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_pend_bin  <= 1'b0;
            r_alu_start <= 1'b0;
            r_count     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            r_count     <= w_count_nxt;
            // A new violation wins over a clear in the same cycle
            if (w_accept && w_illegal) r_err <= 1'b1;
            else if (i_err_clr)        r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_exec && w_is_alu) begin
                        r_state     <= ST_WAIT;
                        r_alu_start <= 1'b1;
                        r_pend_bin  <= (i_cmd == CMD_BINOP);
                    end
                end
                ST_WAIT: begin
                    if (i_alu_done) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_alu_start = r_alu_start;
    assign o_count     = r_count;
    assign o_empty     = w_is_empty;
    assign o_full      = w_is_full;
    assign o_err       = r_err;
    assign o_tdp       = w_is_empty ? '0 : w_q[0];
    assign o_pdp       = w_lt2      ? '0 : w_q[1];

endmodule

// File: tb/tb_pilha_rpn.sv
// -----------------------------------------------------------------------------
// tb_pilha_rpn
// Directed bench for pilha_rpn (WIDTH=8, DEPTH=4). A queue-based stack model
// produces the expected output snapshot for every step; snapshots are queued
// when the step is driven and popped/compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_pilha_rpn;
    import pilha_rpn_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk, rst_n;
    logic          cmd_valid, cmd_ready, alu_start, alu_done, err_clr;
    logic [2:0]    cmd;
    logic [W-1:0]  d, alu_result, tdp, pdp;
    logic [CW-1:0] count;
    logic          empty, full, err;

    pilha_rpn #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cmd_valid  (cmd_valid),
        .i_cmd        (cmd),
        .o_cmd_ready  (cmd_ready),
        .i_d          (d),
        .o_alu_start  (alu_start),
        .i_alu_done   (alu_done),
        .i_alu_result (alu_result),
        .o_tdp        (tdp),
        .o_pdp        (pdp),
        .o_count      (count),
        .o_empty      (empty),
        .o_full       (full),
        .o_err        (err),
        .i_err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [W-1:0]  tdp;
        logic [W-1:0]  pdp;
        logic [CW-1:0] cnt;
        logic          empty, full, err, start, ready;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_fail = 0;

    // Reference model: queue front is TOS
    logic [W-1:0] m_stk[$];
    bit m_err, m_wait, m_bin, m_start;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_stk.delete();
        m_err = 0; m_wait = 0; m_bin = 0; m_start = 0;
    endtask

    task automatic m_step(input bit valid, input logic [2:0] c, input logic [W-1:0] dv,
                          input bit clr, input bit done, input logic [W-1:0] res);
        bit ill;
        logic [W-1:0] t;
        ill = 0;
        m_start = 0;
        if (m_wait) begin
            if (done) begin
                if (m_bin) void'(m_stk.pop_front());
                m_stk[0] = res;
                m_wait = 0;
            end
        end else if (valid) begin
            case (c)
                CMD_PUSH:  if (m_stk.size() == D) ill = 1; else m_stk.push_front(dv);
                CMD_POP:   if (m_stk.size() == 0) ill = 1; else void'(m_stk.pop_front());
                CMD_DUP:   if (m_stk.size() == 0 || m_stk.size() == D) ill = 1;
                           else m_stk.push_front(m_stk[0]);
                CMD_SWAP:  if (m_stk.size() < 2) ill = 1;
                           else begin t = m_stk[0]; m_stk[0] = m_stk[1]; m_stk[1] = t; end
                CMD_BINOP, CMD_UNOP: begin
                    if (m_stk.size() < ((c == CMD_BINOP) ? 2 : 1)) ill = 1;
                    else begin m_wait = 1; m_bin = (c == CMD_BINOP); m_start = 1; end
                end
                CMD_CLEAR: m_stk.delete();
                default: ;
            endcase
        end
        if (ill) m_err = 1;
        else if (clr) m_err = 0;
    endtask

    function automatic exp_t m_snap();
        exp_t e;
        e.tdp   = (m_stk.size() > 0) ? m_stk[0] : '0;
        e.pdp   = (m_stk.size() > 1) ? m_stk[1] : '0;
        e.cnt   = CW'(m_stk.size());
        e.empty = (m_stk.size() == 0);
        e.full  = (m_stk.size() == D);
        e.err   = m_err;
        e.start = m_start;
        e.ready = !m_wait;
        return e;
    endfunction

    task automatic sb_check(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        check({tag, ".tdp"},   tdp,       e.tdp);
        check({tag, ".pdp"},   pdp,       e.pdp);
        check({tag, ".count"}, count,     e.cnt);
        check({tag, ".empty"}, empty,     e.empty);
        check({tag, ".full"},  full,      e.full);
        check({tag, ".err"},   err,       e.err);
        check({tag, ".start"}, alu_start, e.start);
        check({tag, ".ready"}, cmd_ready, e.ready);
    endtask

    // One clock of stimulus: drive at negedge, compare 1 time unit after posedge
    task automatic step(input string tag, input bit valid, input logic [2:0] c,
                        input logic [W-1:0] dv, input bit clr, input bit done,
                        input logic [W-1:0] res);
        @(negedge clk);
        cmd_valid = valid; cmd = c; d = dv; err_clr = clr;
        alu_done = done; alu_result = res;
        m_step(valid, c, dv, clr, done, res);
        sb_q.push_back(m_snap());
        @(posedge clk);
        #1;
        sb_check(tag);
        cmd_valid = 0; err_clr = 0; alu_done = 0;
    endtask

    task automatic do_cmd(input string tag, input logic [2:0] c, input logic [W-1:0] dv);
        step(tag, 1, c, dv, 0, 0, '0);
    endtask

    task automatic do_idle(input string tag, input bit done, input logic [W-1:0] res);
        step(tag, 0, CMD_NOP, '0, 0, done, res);
    endtask

    initial begin
        rst_n = 0; cmd_valid = 0; cmd = CMD_NOP; d = '0;
        alu_done = 0; alu_result = '0; err_clr = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(m_snap());
        sb_check("reset");
        @(negedge clk);
        rst_n = 1;

        // Basic pushes
        do_cmd("push12", CMD_PUSH, 8'h12);
        do_cmd("push34", CMD_PUSH, 8'h34);

        // Fill to DEPTH, overflow push, then clear the error
        do_cmd("push56", CMD_PUSH, 8'h56);
        do_cmd("push78", CMD_PUSH, 8'h78);
        do_cmd("push_full", CMD_PUSH, 8'h99);
        do_cmd("dup_full", CMD_DUP, 8'h00);
        step("err_clr", 0, CMD_NOP, '0, 1, 0, '0);

        // BINOP with a 3-cycle ALU latency; a PUSH during WAIT is ignored
        do_cmd("clear1", CMD_CLEAR, 8'h00);
        do_cmd("push05", CMD_PUSH, 8'h05);
        do_cmd("push03", CMD_PUSH, 8'h03);
        do_cmd("binop", CMD_BINOP, 8'h00);
        do_idle("wait1", 0, 8'h00);
        do_cmd("wait2_push", CMD_PUSH, 8'hAA);
        do_idle("wait3_done", 1, 8'h08);

        // Underflow, and a violation alongside err_clr keeps err set
        do_cmd("clear2", CMD_CLEAR, 8'h00);
        do_cmd("pop_empty", CMD_POP, 8'h00);
        step("pop_empty_clr", 1, CMD_POP, '0, 1, 0, '0);
        step("err_clr2", 0, CMD_NOP, '0, 1, 0, '0);

        // SWAP, DUP, CLEAR
        do_cmd("push0B", CMD_PUSH, 8'h0B);
        do_cmd("push0A", CMD_PUSH, 8'h0A);
        do_cmd("swap", CMD_SWAP, 8'h00);
        do_cmd("dup", CMD_DUP, 8'h00);
        do_cmd("pop", CMD_POP, 8'h00);
        do_cmd("clear3", CMD_CLEAR, 8'h00);

        // Illegal BINOP/SWAP/UNOP never launch the ALU; stray done ignored
        do_cmd("unop_empty", CMD_UNOP, 8'h00);
        do_cmd("push21", CMD_PUSH, 8'h21);
        do_cmd("binop_lt2", CMD_BINOP, 8'h00);
        do_cmd("swap_lt2", CMD_SWAP, 8'h00);
        do_idle("stray_done", 1, 8'hEE);

        // UNOP at minimum turnaround (done on the first WAIT edge)
        do_cmd("unop", CMD_UNOP, 8'h00);
        do_idle("unop_done", 1, 8'h5A);

        // UNOP aborted by reset mid-WAIT
        do_cmd("unop2", CMD_UNOP, 8'h00);
        #3;
        rst_n = 0;
        #1;
        m_reset();
        sb_q.push_back(m_snap());
        sb_check("abort");
        @(negedge clk);
        rst_n = 1;
        do_idle("post_abort_done", 1, 8'hC3);
        do_cmd("post_abort_push", CMD_PUSH, 8'h77);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
